// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-RAM port controller.
// Address/data widths default to the RAM geometry; LEN_WIDTH sizes the burst length field.
package mem_ctrl_pkg;

    localparam int unsigned BUS_WIDTH  = 8;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned LEN_WIDTH  = 2;
    localparam int unsigned MAX_BURST  = 1 << LEN_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/mem_port_ctrl.sv
// CPU-side load/store controller for the split-port data RAM.
// Moore FSM hides the RAM's one-cycle read latency and serialises burst loads.
module mem_port_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = mem_ctrl_pkg::BUS_WIDTH,
    parameter int unsigned DATA_WIDTH = mem_ctrl_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  n_rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [BUS_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [LEN_WIDTH-1:0]  req_len,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,

    output logic                  busy,

    output logic [BUS_WIDTH-1:0]  ram_addr_rd,
    output logic [BUS_WIDTH-1:0]  ram_addr_wr,
    output logic [DATA_WIDTH-1:0] ram_data_wr,
    output logic                  ram_rd_en,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_data_rd
);

    state_e                state_q, state_d;
    logic [BUS_WIDTH-1:0]  cur_addr_q, cur_addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        wdata_d      = wdata_q;
        beats_left_d = beats_left_q;
        rsp_data_d   = rsp_data_q;

        unique case (state_q)
            StIdle: begin
                // req_ready is high exactly in this state, so req_valid alone is the handshake
                if (req_valid) begin
                    cur_addr_d   = req_addr;
                    wdata_d      = req_wdata;
                    beats_left_d = req_we ? '0 : req_len;
                    state_d      = req_we ? StWrite : StRead;
                end
            end
            StWrite: state_d = StIdle;
            StRead:  state_d = StWait;
            StWait: begin
                rsp_data_d = ram_data_rd;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    if (beats_left_q != '0) begin
                        cur_addr_d   = cur_addr_q + BUS_WIDTH'(1);
                        beats_left_d = beats_left_q - LEN_WIDTH'(1);
                        state_d      = StRead;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free Moore decodes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            wdata_q      <= '0;
            beats_left_q <= '0;
            rsp_data_q   <= '0;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            ram_rd_en    <= 1'b0;
            ram_wr_en    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_last     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            wdata_q      <= wdata_d;
            beats_left_q <= beats_left_d;
            rsp_data_q   <= rsp_data_d;
            req_ready    <= (state_d == StIdle);
            busy         <= (state_d != StIdle);
            ram_rd_en    <= (state_d == StRead);
            ram_wr_en    <= (state_d == StWrite);
            rsp_valid    <= (state_d == StResp);
            rsp_last     <= (state_d == StResp) && (beats_left_d == '0);
        end
    end

    assign rsp_data    = rsp_data_q;
    assign ram_addr_rd = cur_addr_q;
    assign ram_addr_wr = cur_addr_q;
    assign ram_data_wr = wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl with a behavioural RAM and reference memory image.
// Stimulus pushes expected RAM accesses and load beats; a negedge monitor pops and compares.
module tb_mem_port_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic [1:0] req_len = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic       busy;
    logic [7:0] ram_addr_rd;
    logic [7:0] ram_addr_wr;
    logic [7:0] ram_data_wr;
    logic       ram_rd_en;
    logic       ram_wr_en;
    logic [7:0] ram_data_rd;

    int n_vec = 0;
    int n_err = 0;
    int rsp_mode = 0;  // 0 always ready, 1 random, 2 stalled, 3 driven by the test directly

    logic [7:0]  ram_mem [256];
    logic [7:0]  ref_mem [256];
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [8:0]  rsp_q [$];
    logic        hold_prev = 1'b0;

    always #5 clk = ~clk;

    mem_port_ctrl u_dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_len     (req_len),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_last    (rsp_last),
        .busy        (busy),
        .ram_addr_rd (ram_addr_rd),
        .ram_addr_wr (ram_addr_wr),
        .ram_data_wr (ram_data_wr),
        .ram_rd_en   (ram_rd_en),
        .ram_wr_en   (ram_wr_en),
        .ram_data_rd (ram_data_rd)
    );

    // Behavioural RAM: registered read, holds data when not enabled.
    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_addr_wr] <= ram_data_wr;
        if (ram_rd_en) ram_data_rd <= ram_mem[ram_addr_rd];
    end

    rd_wr_excl: assert property (@(posedge clk) disable iff (!n_rst) !(ram_rd_en && ram_wr_en))
        else $error("FAIL rd_wr_excl assertion");

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Presents one request at a negedge once the DUT is idle; returns #1 after the accept edge.
    task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] data,
                         input logic [1:0] len, input bit junk);
        int n;
        logic [7:0] a;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_len   = len;
        if (we) begin
            ref_mem[addr] = data;
            wr_q.push_back({addr, data});
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                a = addr + 8'(i);
                rd_q.push_back(a);
                rsp_q.push_back({(i == int'(len)), ref_mem[a]});
            end
        end
        @(posedge clk);
        #1;
        if (junk) begin
            // A store presented while busy must be ignored.
            req_we    = 1'b1;
            req_addr  = 8'($urandom);
            req_wdata = 8'($urandom);
            @(negedge clk);
            check("req_ready_busy", req_ready, 0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check("rsp_valid_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || rd_q.size() != 0 || wr_q.size() != 0 || !req_ready)
               && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("idle_timeout", 0, 1);
    endtask

    // rsp_ready only changes just after a rising edge so the monitor sees the value the DUT uses.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                2:       rsp_ready = 1'b0;
                default: ;
            endcase
        end
    end

    initial begin : monitor
        logic [15:0] exp_w;
        logic [8:0]  exp_r;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                hold_prev = 1'b0;
            end else begin
                check("rd_wr_excl", ram_rd_en & ram_wr_en, 0);
                if (ram_wr_en) begin
                    if (wr_q.size() == 0) check("unexpected_write", 1, 0);
                    else begin
                        exp_w = wr_q.pop_front();
                        check("wr_addr", ram_addr_wr, exp_w[15:8]);
                        check("wr_data", ram_data_wr, exp_w[7:0]);
                    end
                end
                if (ram_rd_en) begin
                    if (rd_q.size() == 0) check("unexpected_read", 1, 0);
                    else check("rd_addr", ram_addr_rd, rd_q.pop_front());
                end
                if (hold_prev) check("rsp_held", rsp_valid, 1);
                if (rsp_valid) begin
                    if (rsp_q.size() == 0) check("unexpected_rsp", 1, 0);
                    else begin
                        exp_r = rsp_q[0];
                        check("rsp_data", rsp_data, exp_r[7:0]);
                        check("rsp_last", rsp_last, exp_r[8]);
                        if (rsp_ready) void'(rsp_q.pop_front());
                    end
                end
                hold_prev = rsp_valid && !rsp_ready;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // Reset state
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_last", rsp_last, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rd_en", ram_rd_en, 0);
        check("rst_wr_en", ram_wr_en, 0);
        check("rst_addr", ram_addr_rd, 0);
        check("rst_wdata", ram_data_wr, 0);
        @(negedge clk);
        n_rst = 1'b1;

        // Fill the whole RAM so the reference image is fully defined
        for (int a = 0; a < 256; a++) issue(1'b1, 8'(a), 8'($urandom), 2'd0, 1'b0);
        wait_idle();

        // Store then load with latency checks
        issue(1'b1, 8'h10, 8'hA5, 2'd0, 1'b0);
        @(negedge clk);
        check("st_wr_en", ram_wr_en, 1);
        check("st_busy", busy, 1);
        check("st_ready", req_ready, 0);
        @(negedge clk);
        check("st_wr_en_end", ram_wr_en, 0);
        check("st_ready_back", req_ready, 1);
        issue(1'b0, 8'h10, 8'h00, 2'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("ld_latency", rsp_valid, (k == 3));
        end
        check("ld_data", rsp_data, 8'hA5);
        check("ld_last", rsp_last, 1);
        wait_idle();

        // Burst load with busy held throughout
        for (int i = 0; i < 4; i++) issue(1'b1, 8'h20 + 8'(i), 8'h01 + 8'(i), 2'd0, 1'b0);
        issue(1'b0, 8'h20, 8'h00, 2'd3, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            check("burst_busy", busy, 1);
            n++;
        end while (!(rsp_valid && rsp_ready && rsp_last) && n < 40);
        @(negedge clk);
        check("burst_done_busy", busy, 0);

        // Wrap-around
        issue(1'b1, 8'hFE, 8'h11, 2'd0, 1'b0);
        issue(1'b1, 8'hFF, 8'h22, 2'd0, 1'b0);
        issue(1'b1, 8'h00, 8'h33, 2'd0, 1'b0);
        issue(1'b0, 8'hFE, 8'h00, 2'd2, 1'b0);
        wait_idle();

        // Backpressure on the first beat of a burst
        rsp_mode = 2;
        issue(1'b0, 8'h20, 8'h00, 2'd3, 1'b1);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_data, 8'h01);
            check("bp_last", rsp_last, 0);
            check("bp_rd_en", ram_rd_en, 0);
            check("bp_ready", req_ready, 0);
        end
        rsp_mode = 0;
        wait_idle();

        // Reset while beat 2 of 4 is being presented
        rsp_mode = 2;
        issue(1'b0, 8'h20, 8'h00, 2'd3, 1'b0);
        wait_valid();
        rsp_mode = 3;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        wait_valid();
        check("rst_beat2_data", rsp_data, 8'h02);
        #1 n_rst = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_rd_en", ram_rd_en, 0);
        rsp_q.delete();
        rd_q.delete();
        wr_q.delete();
        @(negedge clk);
        n_rst = 1'b1;
        rsp_mode = 0;
        issue(1'b0, 8'h22, 8'h00, 2'd1, 1'b0);
        wait_idle();

        // Random traffic with random backpressure and requests while busy
        rsp_mode = 1;
        for (int t = 0; t < 250; t++) begin
            issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rsp_mode = 0;
        wait_idle();
        check("final_rsp_q", rsp_q.size(), 0);
        check("final_rd_q", rd_q.size(), 0);
        check("final_wr_q", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
